axilite_arbiter_2to1: RTL

Two-requester AXI-lite arbiter that shares the single AXI-lite register bus behind the PCIe AXI-to-AXI-lite converter between that converter and a second on-chip master. It admits one transaction at a time, round-robin between requesters, registers every channel, and answers out-of-window addresses locally with DECERR so the downstream bus never sees them.

---
 rtl/axilite_arbiter_2to1.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/axilite_arbiter_2to1.sv
// Two-requester AXI-lite arbiter sharing one downstream register bus.
// One transaction in flight at a time, round-robin between s0 and s1,
// write-before-read within a requester, and out-of-window addresses
// answered locally with DECERR so they never reach the downstream bus.
module axilite_arbiter_2to1 #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_DEAD
) (
    input  logic        aclk,
    input  logic        areset,
    // requester 0
    input  logic [31:0] s0_awaddr,
    input  logic [2:0]  s0_awprot,
    input  logic        s0_awvalid,
    output logic        s0_awready,
    input  logic [31:0] s0_wdata,
    input  logic [3:0]  s0_wstrb,
    input  logic        s0_wvalid,
    output logic        s0_wready,
    output logic [1:0]  s0_bresp,
    output logic        s0_bvalid,
    input  logic        s0_bready,
    input  logic [31:0] s0_araddr,
    input  logic [2:0]  s0_arprot,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    output logic [31:0] s0_rdata,
    output logic [1:0]  s0_rresp,
    output logic        s0_rvalid,
    input  logic        s0_rready,
    // requester 1
    input  logic [31:0] s1_awaddr,
    input  logic [2:0]  s1_awprot,
    input  logic        s1_awvalid,
    output logic        s1_awready,
    input  logic [31:0] s1_wdata,
    input  logic [3:0]  s1_wstrb,
    input  logic        s1_wvalid,
    output logic        s1_wready,
    output logic [1:0]  s1_bresp,
    output logic        s1_bvalid,
    input  logic        s1_bready,
    input  logic [31:0] s1_araddr,
    input  logic [2:0]  s1_arprot,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    output logic [31:0] s1_rdata,
    output logic [1:0]  s1_rresp,
    output logic        s1_rvalid,
    input  logic        s1_rready,
    // shared downstream bus
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] W_FWD  = 3'd1;
    localparam logic [2:0] B_WAIT = 3'd2;
    localparam logic [2:0] B_RESP = 3'd3;
    localparam logic [2:0] AR_FWD = 3'd4;
    localparam logic [2:0] R_WAIT = 3'd5;
    localparam logic [2:0] R_RESP = 3'd6;

    logic [2:0]  state;
    logic        last;      // last granted requester
    logic        gnt;       // requester owning the current transaction
    logic [31:0] addr_q;
    logic [2:0]  prot_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;

    function automatic logic addr_hit(input logic [31:0] a);
        return (a & ADDR_MASK) == ADDR_BASE;
    endfunction

    logic        wr0, wr1, req0, req1, sel, sel_wr, grant, hit;
    logic [31:0] cand_addr;
    logic [2:0]  cand_prot;
    logic        up_bready, up_rready;

    assign wr0  = s0_awvalid & s0_wvalid;
    assign wr1  = s1_awvalid & s1_wvalid;
    assign req0 = wr0 | s0_arvalid;
    assign req1 = wr1 | s1_arvalid;
    // On a tie the requester that did not win last time goes next.
    assign sel    = (req0 & req1) ? ~last : req1;
    assign sel_wr = sel ? wr1 : wr0;
    assign grant  = (state == IDLE) && (req0 | req1) && !areset;

    assign cand_addr = sel ? (sel_wr ? s1_awaddr : s1_araddr)
                           : (sel_wr ? s0_awaddr : s0_araddr);
    assign cand_prot = sel ? (sel_wr ? s1_awprot : s1_arprot)
                           : (sel_wr ? s0_awprot : s0_arprot);
    assign hit = addr_hit(cand_addr);

    assign s0_awready = grant && !sel && sel_wr;
    assign s0_wready  = grant && !sel && sel_wr;
    assign s0_arready = grant && !sel && !sel_wr;
    assign s1_awready = grant && sel && sel_wr;
    assign s1_wready  = grant && sel && sel_wr;
    assign s1_arready = grant && sel && !sel_wr;

    assign s0_bvalid = (state == B_RESP) && !gnt;
    assign s1_bvalid = (state == B_RESP) && gnt;
    assign s0_rvalid = (state == R_RESP) && !gnt;
    assign s1_rvalid = (state == R_RESP) && gnt;
    assign s0_bresp  = bresp_q;
    assign s1_bresp  = bresp_q;
    assign s0_rresp  = rresp_q;
    assign s1_rresp  = rresp_q;
    assign s0_rdata  = rdata_q;
    assign s1_rdata  = rdata_q;
    assign up_bready = gnt ? s1_bready : s0_bready;
    assign up_rready = gnt ? s1_rready : s0_rready;

    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_awprot = prot_q;
    assign m_arprot = prot_q;
    assign m_wdata  = wdata_q;
    assign m_wstrb  = wstrb_q;
    assign m_bready = (state == B_WAIT);
    assign m_rready = (state == R_WAIT);

    // Capture the winning request; held until the next grant.
    always_ff @(posedge aclk) begin
        if (grant) begin
            addr_q  <= cand_addr;
            prot_q  <= cand_prot;
            wdata_q <= sel ? s1_wdata : s0_wdata;
            wstrb_q <= sel ? s1_wstrb : s0_wstrb;
        end
    end

    // Transaction sequencer; forward states exit once every valid has dropped.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt       <= 1'b0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_arvalid <= 1'b0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        last <= sel;
                        gnt  <= sel;
                        if (sel_wr) begin
                            if (hit) begin
                                m_awvalid <= 1'b1;
                                m_wvalid  <= 1'b1;
                                state     <= W_FWD;
                            end else begin
                                bresp_q <= 2'b11;
                                state   <= B_RESP;
                            end
                        end else begin
                            if (hit) begin
                                m_arvalid <= 1'b1;
                                state     <= AR_FWD;
                            end else begin
                                rresp_q <= 2'b11;
                                rdata_q <= ERR_RDATA;
                                state   <= R_RESP;
                            end
                        end
                    end
                end
                W_FWD: begin
                    if (m_awvalid && m_awready) m_awvalid <= 1'b0;
                    if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
                    if (!m_awvalid && !m_wvalid) state <= B_WAIT;
                end
                B_WAIT: begin
                    if (m_bvalid) begin
                        bresp_q <= m_bresp;
                        state   <= B_RESP;
                    end
                end
                B_RESP: begin
                    if (up_bready) state <= IDLE;
                end
                AR_FWD: begin
                    if (m_arvalid && m_arready) m_arvalid <= 1'b0;
                    if (!m_arvalid) state <= R_WAIT;
                end
                R_WAIT: begin
                    if (m_rvalid) begin
                        rdata_q <= m_rdata;
                        rresp_q <= m_rresp;
                        state   <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (up_rready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
